// File: rtl/erm16_bus_arbiter.sv
// ERM16 bus arbiter: shares one memory/IO bus between NREQ masters (0 = CPU), round-robin with bounded bursts.
// Latency: req sampled in IDLE -> ack after WAIT_CYCLES+2 cycles; one access every WAIT_CYCLES+3 cycles.
// Backpressure: a master holds req (level) until its one-cycle ack; requests are only evaluated in IDLE.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   req/m_addr/m_wdata/m_we   per-master request level and access (16-bit lanes, master i at [16i+15:16i])
//   gnt, ack                  one-hot grant (during access) and one-hot completion pulse
//   rdata                     read data, valid in ack cycle, held until the next read completes
//   mem_addr/mem_wdata/mem_we bus outputs, stable for the whole access
//   mem_rdata                 bus read data, sampled on the last access cycle
//   busy                      high whenever the arbiter is not IDLE
module erm16_bus_arbiter #(
  parameter int NREQ        = 3,
  parameter int WAIT_CYCLES = 1,
  parameter int MAX_BURST   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   m_addr,
  input  logic [16*NREQ-1:0]   m_wdata,
  input  logic [NREQ-1:0]      m_we,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ack,
  output logic [15:0]          rdata,
  output logic [15:0]          mem_addr,
  output logic [15:0]          mem_wdata,
  output logic                 mem_we,
  input  logic [15:0]          mem_rdata,
  output logic                 busy
);

  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW1 = PW + 1;
  localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_CYCLES);
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [PW-1:0]   owner, owner_nxt;
  logic [3:0]      burst_cnt, burst_cnt_nxt;
  logic [3:0]      wait_cnt, wait_cnt_nxt;
  logic            last_vld, last_vld_nxt;
  logic [NREQ-1:0] gnt_nxt, ack_nxt;
  logic [15:0]     rdata_nxt, mem_addr_nxt, mem_wdata_nxt;
  logic            mem_we_nxt;
  logic            busy_nxt;

  logic            owner_req, cont, win_found;
  logic [PW-1:0]   scan_start, win_idx, sel;
  logic [PW1-1:0]  scan_pos;
  logic [15:0]     sel_addr, sel_wdata;
  logic            sel_we;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
    return (i == PW'(NREQ - 1)) ? '0 : i + PW'(1);
  endfunction

  // Burst continuation: the previous owner still requests and has burst budget left.
  always_comb begin
    owner_req = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == PW'(i)) owner_req = req[i];
    end
    cont = last_vld && owner_req && (burst_cnt < BURST_LAST);
  end

  // Round-robin scan. When a burst just ended the scan starts after the old owner;
  // this is the same value ptr takes at this IDLE, so the pointer update and the
  // scan agree within one cycle. Scanning k downwards lets the lowest offset win.
  always_comb begin
    scan_start = last_vld ? wrap_inc(owner) : ptr;
    win_found  = 1'b0;
    win_idx    = '0;
    scan_pos   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_pos = {1'b0, scan_start} + PW1'(k);
      if (scan_pos >= PW1'(NREQ)) scan_pos = scan_pos - PW1'(NREQ);
      for (int i = 0; i < NREQ; i++) begin
        if ((scan_pos == PW1'(i)) && req[i]) begin
          win_found = 1'b1;
          win_idx   = PW'(i);
        end
      end
    end
  end

  // Select the winning master's access fields.
  always_comb begin
    sel       = cont ? owner : win_idx;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == PW'(i)) begin
        sel_addr  = m_addr[16*i +: 16];
        sel_wdata = m_wdata[16*i +: 16];
        sel_we    = m_we[i];
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    owner_nxt     = owner;
    burst_cnt_nxt = burst_cnt;
    wait_cnt_nxt  = wait_cnt;
    last_vld_nxt  = last_vld;
    gnt_nxt       = gnt;
    ack_nxt       = '0;
    rdata_nxt     = rdata;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    mem_we_nxt    = mem_we;

    unique case (state)
      IDLE: begin
        mem_we_nxt = 1'b0;
        if (cont) begin
          burst_cnt_nxt = burst_cnt + 4'd1;
        end else begin
          if (last_vld) begin
            ptr_nxt      = wrap_inc(owner);
            last_vld_nxt = 1'b0;
          end
          if (win_found) begin
            owner_nxt     = win_idx;
            burst_cnt_nxt = 4'd0;
          end
        end
        if (cont || win_found) begin
          state_nxt     = ACCESS;
          gnt_nxt       = NREQ'(1) << sel;
          mem_addr_nxt  = sel_addr;
          mem_wdata_nxt = sel_wdata;
          mem_we_nxt    = sel_we;
          wait_cnt_nxt  = WAIT_LOAD;
        end
      end
      ACCESS: begin
        if (wait_cnt == 4'd0) begin
          state_nxt  = RESP;
          gnt_nxt    = '0;
          mem_we_nxt = 1'b0;
          ack_nxt    = gnt;
          // Writes leave the previously read value visible.
          if (!mem_we) rdata_nxt = mem_rdata;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
        end
      end
      RESP: begin
        state_nxt    = IDLE;
        last_vld_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      wait_cnt  <= '0;
      last_vld  <= 1'b0;
      gnt       <= '0;
      ack       <= '0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      owner     <= owner_nxt;
      burst_cnt <= burst_cnt_nxt;
      wait_cnt  <= wait_cnt_nxt;
      last_vld  <= last_vld_nxt;
      gnt       <= gnt_nxt;
      ack       <= ack_nxt;
      rdata     <= rdata_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      mem_we    <= mem_we_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule
